// File: rtl/wb_ram64_bridge_if.sv
// Bus bundle for wb_ram64_bridge: Wishbone B4 classic slave side plus RAM macro strobes.
interface wb_ram64_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [7:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [63:0] wb_dat_i;
    logic [63:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [8:0]  ram_a;
    logic [63:0] ram_di;
    logic [63:0] ram_do;

    // Bridge side: receives bus requests and RAM read data.
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, ram_do,
        output wb_dat_o, wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di
    );

    // Environment side: bus master plus the RAM macro.
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i, ram_do,
        input  wb_dat_o, wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di
    );
endinterface

// File: rtl/wb_ram64_bridge.sv
// Wishbone B4 classic 64-bit slave in front of a 512x64 synchronous RAM.
// One transaction outstanding; out-of-window addresses terminate with err.
module wb_ram64_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          REG_OUT   = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    wb_ram64_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, ERR} state_t;

    state_t      state;
    logic        ack;
    logic        err;
    logic        rd_ack;   // current ack terminates a read, so data is driven
    logic [63:0] rd_reg;
    logic        hit;
    logic        req;
    logic        unused_adr;

    assign hit = (bus.wb_adr_i[31:12] == BASE_ADDR[31:12]);
    // RST_N gates the request so the RAM is never strobed while in reset.
    assign req = RST_N & bus.wb_cyc_i & bus.wb_stb_i & (state == IDLE) & ~ack & ~err;

    // RAM strobes only fire from IDLE, so the write commits on the request edge.
    assign bus.ram_en = req & hit;
    assign bus.ram_we = (req & hit & bus.wb_we_i) ? bus.wb_sel_i : 8'h00;
    assign bus.ram_a  = bus.wb_adr_i[11:3];
    assign bus.ram_di = bus.wb_dat_i;

    assign bus.wb_ack_o = ack;
    assign bus.wb_err_o = err;
    // Without the output register, ram_do is valid exactly in the ack cycle.
    assign bus.wb_dat_o = rd_ack ? ((REG_OUT != 0) ? rd_reg : bus.ram_do) : 64'h0;

    // Byte offset within the word is carried by wb_sel_i instead.
    assign unused_adr = ^bus.wb_adr_i[2:0];

    // Transaction FSM; ack/err are one-cycle pulses set on entry to RESP/ERR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            ack    <= 1'b0;
            err    <= 1'b0;
            rd_ack <= 1'b0;
            rd_reg <= 64'h0;
        end else begin
            ack    <= 1'b0;
            err    <= 1'b0;
            rd_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!hit) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (bus.wb_we_i) begin
                            state <= RESP;
                            ack   <= 1'b1;
                        end else if (REG_OUT != 0) begin
                            state <= RD_WAIT;
                        end else begin
                            state  <= RESP;
                            ack    <= 1'b1;
                            rd_ack <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    // Master dropping cyc here abandons the read silently.
                    if (!bus.wb_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        rd_reg <= bus.ram_do;
                        state  <= RESP;
                        ack    <= 1'b1;
                        rd_ack <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram64_bridge.sv
// Self-checking bench: two bridges (direct and registered read data), each with
// its own RAM macro model, checked against a word-level memory reference.
module tb_wb_ram64_bridge;
    localparam logic [31:0] BASE [2] = '{32'h0000_0000, 32'h8000_0000};
    localparam int          REGO [2] = '{0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  cyc = '0, stb = '0, we = '0;
    logic [7:0]  sel [2];
    logic [31:0] adr [2];
    logic [63:0] dat [2];
    logic [63:0] dat_o [2];
    logic [1:0]  ack, err, ram_en;
    logic [7:0]  ram_we [2];
    logic [8:0]  ram_a [2];
    logic [63:0] ram_di [2];
    logic [63:0] rdo0, rdo1;
    logic [63:0] mem0 [512];
    logic [63:0] mem1 [512];
    logic [63:0] ref_mem [2][512];

    int checks = 0;
    int fails = 0;

    wb_ram64_bridge_if bus0();
    wb_ram64_bridge_if bus1();

    wb_ram64_bridge #(.BASE_ADDR(32'h0000_0000), .REG_OUT(0)) u_dut0 (.CLK(clk), .RST_N(rst_n), .bus(bus0));
    wb_ram64_bridge #(.BASE_ADDR(32'h8000_0000), .REG_OUT(1)) u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));

    assign bus0.wb_cyc_i = cyc[0];  assign bus1.wb_cyc_i = cyc[1];
    assign bus0.wb_stb_i = stb[0];  assign bus1.wb_stb_i = stb[1];
    assign bus0.wb_we_i  = we[0];   assign bus1.wb_we_i  = we[1];
    assign bus0.wb_sel_i = sel[0];  assign bus1.wb_sel_i = sel[1];
    assign bus0.wb_adr_i = adr[0];  assign bus1.wb_adr_i = adr[1];
    assign bus0.wb_dat_i = dat[0];  assign bus1.wb_dat_i = dat[1];
    assign bus0.ram_do   = rdo0;    assign bus1.ram_do   = rdo1;
    assign dat_o[0] = bus0.wb_dat_o; assign dat_o[1] = bus1.wb_dat_o;
    assign ack[0] = bus0.wb_ack_o;   assign ack[1] = bus1.wb_ack_o;
    assign err[0] = bus0.wb_err_o;   assign err[1] = bus1.wb_err_o;
    assign ram_en[0] = bus0.ram_en;  assign ram_en[1] = bus1.ram_en;
    assign ram_we[0] = bus0.ram_we;  assign ram_we[1] = bus1.ram_we;
    assign ram_a[0] = bus0.ram_a;    assign ram_a[1] = bus1.ram_a;
    assign ram_di[0] = bus0.ram_di;  assign ram_di[1] = bus1.ram_di;

    // RAM_512x64 models: byte-write, one-cycle synchronous read of the old word.
    always @(posedge clk) begin
        if (ram_en[0]) begin
            for (int b = 0; b < 8; b++)
                if (ram_we[0][b]) mem0[ram_a[0]][8*b +: 8] <= ram_di[0][8*b +: 8];
            rdo0 <= mem0[ram_a[0]];
        end
    end
    always @(posedge clk) begin
        if (ram_en[1]) begin
            for (int b = 0; b < 8; b++)
                if (ram_we[1][b]) mem1[ram_a[1]][8*b +: 8] <= ram_di[1][8*b +: 8];
            rdo1 <= mem1[ram_a[1]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Protocol monitor: pulses exclusive and single-cycle, data quiet outside acks.
    bit [1:0] pa = '0, pe = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk("ack_err_excl", ack[k] & err[k], 0);
                chk("ack_twice", ack[k] & pa[k], 0);
                chk("err_twice", err[k] & pe[k], 0);
                if (!ack[k]) chk("dat_idle", dat_o[k], 0);
            end
        end
        pa = ack;
        pe = err;
    end

    // Word-level reference: a hit write merges selected bytes, a hit read returns the word.
    task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [7:0] s,
                        input logic [63:0] d, input bit hold);
        bit hit;
        bit done;
        int n;
        int lat;
        logic [63:0] exp;
        hit = (a[31:12] == BASE[k][31:12]);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat[k] = d;
        #1;
        chk("req_en", ram_en[k], hit);
        if (hit) begin
            chk("req_a", ram_a[k], a[11:3]);
            chk("req_we", ram_we[k], w ? s : 8'h00);
            if (w) chk("req_di", ram_di[k], d);
        end
        exp = 64'h0;
        if (hit && w) begin
            for (int b = 0; b < 8; b++)
                if (s[b]) ref_mem[k][a[11:3]][8*b +: 8] = d[8*b +: 8];
        end else if (hit) begin
            exp = ref_mem[k][a[11:3]];
        end
        lat = (hit && !w) ? 1 + REGO[k] : 1;
        n = 0;
        done = 1'b0;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack[k] | err[k]) done = 1'b1;
            else chk("wait_en", ram_en[k], 0);
        end
        chk("latency", n, lat);
        chk("ack", ack[k], hit);
        chk("err", err[k], !hit);
        chk("dat_o", dat_o[k], exp);
        if (!hold) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        @(posedge clk); #1;
        chk("pulse_end", ack[k] | err[k], 0);
    endtask

    task automatic run_suite(input int k);
        logic [31:0] b;
        logic [31:0] a;
        logic [63:0] d;
        b = BASE[k];
        // Reset held with a live request: nothing may reach the RAM or the bus.
        @(negedge clk);
        rst_n = 1'b0;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = b + 32'hFF8;
        sel[k] = 8'hFF; dat[k] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_en", ram_en[k], 0);
            chk("rst_we", ram_we[k], 0);
            chk("rst_ack", ack[k] | err[k], 0);
            chk("rst_dat", dat_o[k], 0);
            @(negedge clk);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        xact(k, 1, b + 32'hFF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
        xact(k, 0, b + 32'hFF8, 8'h00, 64'h0, 0);
        // Partial and empty byte-lane writes.
        xact(k, 1, b, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        xact(k, 1, b + 32'h4, 8'h0F, 64'h0, 0);
        xact(k, 0, b, 8'h01, 64'h0, 0);
        chk("merge_word0", ref_mem[k][0], 64'hFFFF_FFFF_0000_0000);
        xact(k, 1, b, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        xact(k, 0, b, 8'hFF, 64'h0, 0);
        // Out-of-window accesses.
        xact(k, 0, b + 32'h1000, 8'hFF, 64'h0, 0);
        xact(k, 1, b ^ 32'h8000_0000, 8'hFF, 64'h55, 0);
        // Registered-read abort, then a clean read of word 5.
        xact(k, 1, b + 32'h28, 8'hFF, {$urandom, $urandom}, 0);
        if (REGO[k] != 0) begin
            @(negedge clk);
            cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0; adr[k] = b + 32'h18; sel[k] = 8'hFF;
            @(posedge clk); #1;
            chk("abort_en", ram_en[k], 0);
            cyc[k] = 1'b0; stb[k] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                chk("abort_ack", ack[k] | err[k], 0);
            end
        end
        xact(k, 0, b + 32'h28, 8'hFF, 64'h0, 0);
        // Reset in the ack cycle: pulse cleared at once, the write stays committed.
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; adr[k] = b + 32'h48; sel[k] = 8'hFF;
        d = {$urandom, $urandom};
        dat[k] = d;
        ref_mem[k][9] = d;
        @(posedge clk); #1;
        chk("mr_ack_pre", ack[k], 1);
        rst_n = 1'b0;
        #1;
        chk("mr_ack", ack[k], 0);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        xact(k, 0, b + 32'h48, 8'hFF, 64'h0, 0);
        // Back-to-back reads of words 0..7 with stb held through the acks.
        for (int i = 1; i < 8; i++) xact(k, 1, b + 32'(i * 8), 8'hFF, {$urandom, $urandom}, 0);
        for (int i = 0; i < 8; i++) xact(k, 0, b + 32'(i * 8), 8'($urandom), 64'h0, 1);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        // Random mix of reads, writes and misses; low address bits are junk.
        for (int i = 0; i < 40; i++) begin
            a = b + {20'h0, 9'($urandom_range(0, 511)), 3'($urandom)};
            if ($urandom_range(0, 7) == 0) a = a + 32'(($urandom_range(1, 255)) << 12);
            xact(k, 1'($urandom), a, 8'($urandom), {$urandom, $urandom}, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 64'h0;
            mem1[i] = 64'h0;
            ref_mem[0][i] = 64'h0;
            ref_mem[1][i] = 64'h0;
        end
        for (int k = 0; k < 2; k++) begin
            sel[k] = 8'h00; adr[k] = 32'h0; dat[k] = 64'h0;
        end
        rdo0 = 64'h0;
        rdo1 = 64'h0;
        repeat (3) @(posedge clk);
        run_suite(0);
        run_suite(1);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "bench watchdog");
    end
endmodule

// File: doc/wb_ram64_bridge.md
Name: wb_ram64_bridge

Overview:
- Wishbone B4 classic 64-bit slave that drives one RAM_512x64 macro (512 words x 64 bits, per-byte write enables, synchronous read of one cycle).
- Sits directly upstream of the RAM. It decodes the bus address, generates the EN/WE/A/Di strobes, and returns Do to the bus master with ack/err handshaking.
- Only one transaction is outstanding at a time.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the 4 KiB window; its low 12 bits must be zero.
- REG_OUT, 0, 0 = return ram_do directly in the ack cycle; 1 = register ram_do first (adds one cycle of read latency and improves timing).

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_sel_i  in  8  byte selects; bit n covers bits [8n+7:8n]
- wb_adr_i  in  32  byte address
- wb_dat_i  in  64  write data
- wb_dat_o  out  64  read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (address outside the window)
- ram_en  out  1  to RAM EN
- ram_we  out  8  to RAM WE
- ram_a  out  9  to RAM A (word address)
- ram_di  out  64  to RAM Di
- ram_do  in  64  from RAM Do; valid the cycle after an EN edge

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- While RST_N is low:
  - state = IDLE;
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0;
  - ram_en = 0, ram_we = 0; the read-data register is 0.
- Address decode:
  - hit = (wb_adr_i[31:12] == BASE_ADDR[31:12]);
  - ram_a = wb_adr_i[11:3];
  - wb_adr_i[2:0] are ignored; byte lanes come from wb_sel_i.
- req = wb_cyc_i & wb_stb_i & (state == IDLE) & ~wb_ack_o & ~wb_err_o.
- RAM strobes are combinational in IDLE only:
  - ram_en = req & hit;
  - ram_we = (req & hit & wb_we_i) ? wb_sel_i : 8'h00;
  - ram_di = wb_dat_i;
  - in every other state ram_en = 0 and ram_we = 0.
- FSM states: IDLE, RD_WAIT, RESP, ERR.
- IDLE:
  - req & ~hit -> ERR. No RAM access.
  - req & hit & write -> RESP. The write commits at this edge.
  - req & hit & read -> RESP when REG_OUT = 0; RD_WAIT when REG_OUT = 1.
  - Otherwise stay in IDLE.
- RD_WAIT (REG_OUT = 1 only):
  - Capture ram_do into the read register, then go to RESP.
  - If wb_cyc_i is low, this is an abort: go to IDLE, no ack, register unchanged.
- RESP:
  - wb_ack_o = 1 for exactly one cycle (registered, set on entry).
  - Return to IDLE unconditionally.
- ERR:
  - wb_err_o = 1 for exactly one cycle.
  - Return to IDLE.
- Throughput and latency (cycles from request sampled to ack):
  - writes: 1 cycle (2 cycles per transaction);
  - reads with REG_OUT = 0: 1 cycle;
  - reads with REG_OUT = 1: 2 cycles (3 per transaction).
- ack and err are never high together. They are never high for two consecutive cycles.
- wb_dat_o:
  - REG_OUT = 0: equals ram_do while acking a read;
  - REG_OUT = 1: equals the read register while acking a read;
  - otherwise 0, including during write acks and err.
- A read returns the full 64-bit word regardless of wb_sel_i.
- Write with wb_sel_i = 0: ram_en pulses, ram_we = 0, ack is returned and the RAM is unchanged.
- Master holding stb across an ack: no re-issue in the ack cycle. The next request is sampled in the following IDLE cycle.
- wb_cyc_i dropping in the RESP or ERR cycle: the pulse still completes; the master ignores it.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs cleared and no ack. A write already clocked into the RAM is not undone.

Test Plan:
- Reset with stb high, then release: no ram_en/ack while RST_N = 0. The first sampled request is serviced normally.
- Write adr 0x0000_0FF8, sel 8'hFF, data 64'h0123_4567_89AB_CDEF; then read the same address.
  - Write: ram_a = 9'h1FF, ram_we = 8'hFF, ack 1 cycle later.
  - Read: dat_o = 64'h0123_4567_89AB_CDEF with ack, 1 cycle (REG_OUT = 0) or 2 cycles (REG_OUT = 1) after the request.
- Write word 0 = 64'hFFFF_FFFF_FFFF_FFFF, then write sel 8'h0F with data 0, then read word 0 -> 64'hFFFF_FFFF_0000_0000. Then write sel 8'h00 -> word unchanged.
- Access at adr 0x0000_1000 with BASE_ADDR = 0 -> wb_err_o for 1 cycle, ram_en never high, wb_ack_o stays 0.
- REG_OUT = 1 read, drop wb_cyc_i in the RD_WAIT cycle -> no ack, FSM back to IDLE. A following read of word 5 returns the correct data.
- Back-to-back reads of words 0..7 with stb held high -> exactly one ack per word with the correct data. ack is never high two consecutive cycles; dat_o = 0 between acks.
